// File: rtl/pes_fmul_seq.sv
// pes_fmul_seq: issue/collect sequencer for the pes_fmul 4-bit fraction multiplier.
// Operand pairs are queued in a small FIFO, launched one at a time with a
// one-cycle St pulse, and the 7-bit product is presented on a valid/ready port.
// A Done timeout returns a zero result and raises a sticky Err so a hung
// multiplier cannot stall the pipeline.
module pes_fmul_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       In_Valid,
    output logic       In_Ready,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       St,
    output logic [3:0] Mplier,
    output logic [3:0] Mcand,
    input  logic [6:0] Product,
    input  logic       Done,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic [6:0] Result,
    output logic       Err,
    output logic [7:0] Ops
);

    // Pointer, occupancy and timeout counter widths.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    // Operand FIFO storage: each entry is {A, B}.
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          in_ready_r;

    // Sequencer state and registered outputs.
    state_t        state_r;
    logic          st_r;
    logic [3:0]    mplier_r;
    logic [3:0]    mcand_r;
    logic          out_valid_r;
    logic [6:0]    result_r;
    logic          err_r;
    logic [7:0]    ops_r;
    logic [TW-1:0] tmo_cnt_r;

    // Combinational handshake decode.
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_next_s;
    logic [7:0]    head_s;

    // FIFO push/pop decisions and next occupancy; the pop only happens when
    // the result slot is free or being drained on this same edge.
    always_comb begin
        push_s       = In_Valid && in_ready_r;
        pop_s        = (state_r == S_IDLE) && (count_r != '0) &&
                       (!out_valid_r || Out_Ready);
        head_s       = mem_r[rd_ptr_r];
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage write; entries are cleared on reset so the head is never X.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {A, B};
        end
    end

    // FIFO pointers, occupancy and the registered full flag (In_Ready); the
    // ready flag only looks at the stored occupancy, so no full-bypass exists.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // Sequencer: launch the FIFO head, wait for Done or timeout, and hold the
    // captured result until the consumer takes it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= S_IDLE;
            st_r        <= 1'b0;
            mplier_r    <= 4'd0;
            mcand_r     <= 4'd0;
            out_valid_r <= 1'b0;
            result_r    <= 7'd0;
            err_r       <= 1'b0;
            ops_r       <= 8'd0;
            tmo_cnt_r   <= '0;
        end else begin
            // Drain the result slot; a capture later in this block overrides.
            if (out_valid_r && Out_Ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: begin
                    st_r <= 1'b0;
                    if (pop_s) begin
                        mplier_r <= head_s[7:4];
                        mcand_r  <= head_s[3:0];
                        st_r     <= 1'b1;
                        state_r  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    st_r      <= 1'b0;
                    tmo_cnt_r <= '0;
                    state_r   <= S_WAIT;
                end
                S_WAIT: begin
                    st_r <= 1'b0;
                    if (Done) begin
                        // Done wins over a timeout expiring on the same cycle.
                        result_r    <= Product;
                        out_valid_r <= 1'b1;
                        ops_r       <= ops_r + 8'd1;
                        state_r     <= S_IDLE;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        result_r    <= 7'd0;
                        out_valid_r <= 1'b1;
                        err_r       <= 1'b1;
                        state_r     <= S_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    end
                end
                default: begin
                    st_r    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign In_Ready  = in_ready_r;
    assign St        = st_r;
    assign Mplier    = mplier_r;
    assign Mcand     = mcand_r;
    assign Out_Valid = out_valid_r;
    assign Result    = result_r;
    assign Err       = err_r;
    assign Ops       = ops_r;

endmodule
